// File: rtl/axi_cpu_manager_pkg.sv
// Shared types for the CPU-model AXI manager.
//   - AXI channel payload structs (aw/w/b/ar/r) and the OKAY response code.
//   - Manager FSM state enum.
//   - Address and data generators for pair index idx of a given CPU slot.
package axi_cpu_manager_pkg;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_DATA_W-1:0] data;
    } axi_r_t;

    typedef enum logic [2:0] {
        IDLE, WR, WAIT_B, RD, WAIT_R, GAP, DONE
    } mgr_state_t;

    // Each CPU owns a 1024-entry window of 8-byte words; idx wraps inside it.
    function automatic logic [AXI_ADDR_W-1:0] mgr_addr(input logic [31:0] cpu_id,
                                                       input logic [31:0] idx);
        return ((cpu_id << 10) + {22'd0, idx[9:0]}) << 3;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] mgr_data(input logic [7:0]  cpu_id,
                                                       input logic [31:0] idx,
                                                       input logic [63:0] seed);
        return {cpu_id, 24'h0, idx} ^ seed;
    endfunction

endpackage

// File: rtl/axi_cpu_manager_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to draw random idle gaps.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   en         : advance one step
//   q          : current LFSR state
// SEED must be nonzero or the register locks up at zero.
module axi_lfsr16 #(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= SEED;
        else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/axi_cpu_manager.sv
// AXI manager modelling one CPU: issues TRANSACTION_NB write/read-back pairs
// into its private 1024-word window and counts every bad or unexpected
// response.
//   clk, rst_n              : clock, async active-low reset
//   o_axi_m_aw/awvalid/...  : AW channel (id = CPU_ID)
//   o_axi_m_w/wvalid/...    : W channel
//   i_axi_m_b/bvalid/bready : B channel
//   o_axi_m_ar/arvalid/...  : AR channel
//   i_axi_m_r/rvalid/rready : R channel
//   o_done                  : all pairs complete (sticky until reset)
//   o_err_cnt               : saturating error count
// Build option AXI_CPU_MANAGER_RANDOM_GAP_EN inserts an LFSR-driven 0..7
// cycle idle gap after each B and each R response.
module axi_cpu_manager
    import axi_cpu_manager_pkg::*;
#(
    parameter int          CPU_ID         = 0,
    parameter int          TRANSACTION_NB = 1000,
    parameter logic [63:0] DATA_SEED      = 64'hA5A5_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output axi_aw_t     o_axi_m_aw,
    output logic        o_axi_m_awvalid,
    input  logic        i_axi_m_awready,
    output axi_w_t      o_axi_m_w,
    output logic        o_axi_m_wvalid,
    input  logic        i_axi_m_wready,
    input  axi_b_t      i_axi_m_b,
    input  logic        i_axi_m_bvalid,
    output logic        o_axi_m_bready,
    output axi_ar_t     o_axi_m_ar,
    output logic        o_axi_m_arvalid,
    input  logic        i_axi_m_arready,
    input  axi_r_t      i_axi_m_r,
    input  logic        i_axi_m_rvalid,
    output logic        o_axi_m_rready,
    output logic        o_done,
    output logic [15:0] o_err_cnt
);

    localparam logic [AXI_ID_W-1:0] ID = AXI_ID_W'(CPU_ID);

    mgr_state_t      state, state_n, tgt;
    logic            hop;
    logic [31:0]     idx, idx_n;
    logic            aw_done, aw_done_n, w_done, w_done_n;
    logic            aw_fire, w_fire, b_bad, r_bad;
    logic [1:0]      err_inc;
    logic [16:0]     err_sum;
    logic [15:0]     err_cnt;
    logic [AXI_ADDR_W-1:0] cur_addr;
    logic [AXI_DATA_W-1:0] cur_data;

    assign cur_addr = mgr_addr(32'(CPU_ID), idx);
    assign cur_data = mgr_data(8'(CPU_ID), idx, DATA_SEED);

    // Valids/readies decode from the state register only, so they never
    // follow a ready/valid input combinationally.
    assign o_axi_m_awvalid = (state == WR) && !aw_done;
    assign o_axi_m_wvalid  = (state == WR) && !w_done;
    assign o_axi_m_bready  = (state == WAIT_B);
    assign o_axi_m_arvalid = (state == RD);
    assign o_axi_m_rready  = (state == WAIT_R);
    assign o_done          = (state == DONE);
    assign o_err_cnt       = err_cnt;

    // Payloads are zero outside their issuing state; idx is frozen while
    // the state is held, so payload is stable until the handshake.
    always_comb begin
        o_axi_m_aw = '0;
        o_axi_m_w  = '0;
        o_axi_m_ar = '0;
        if (state == WR) begin
            o_axi_m_aw.id   = ID;
            o_axi_m_aw.addr = cur_addr;
            o_axi_m_w.data  = cur_data;
        end
        if (state == RD) begin
            o_axi_m_ar.id   = ID;
            o_axi_m_ar.addr = cur_addr;
        end
    end

    assign aw_fire = o_axi_m_awvalid && i_axi_m_awready;
    assign w_fire  = o_axi_m_wvalid  && i_axi_m_wready;

    // A response is bad if it is malformed or arrives outside its wait state.
    assign b_bad = i_axi_m_bvalid && ((state != WAIT_B) || (i_axi_m_b.id != ID) ||
                                      (i_axi_m_b.resp != AXI_RESP_OKAY));
    assign r_bad = i_axi_m_rvalid && ((state != WAIT_R) || (i_axi_m_r.id != ID) ||
                                      (i_axi_m_r.resp != AXI_RESP_OKAY) ||
                                      (i_axi_m_r.data != cur_data));
    assign err_inc = {1'b0, b_bad} + {1'b0, r_bad};
    assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

`ifdef AXI_CPU_MANAGER_RANDOM_GAP_EN
    logic [15:0] lfsr_q;
    logic        lfsr_step;
    logic [2:0]  gap_cnt, gap_cnt_n;
    mgr_state_t  gap_ret, gap_ret_n;

    axi_lfsr16 #(.SEED(16'(CPU_ID + 1))) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_step),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            gap_ret <= IDLE;
        end else begin
            gap_cnt <= gap_cnt_n;
            gap_ret <= gap_ret_n;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        hop       = 1'b0;
        tgt       = IDLE;
`ifdef AXI_CPU_MANAGER_RANDOM_GAP_EN
        lfsr_step = 1'b0;
        gap_cnt_n = gap_cnt;
        gap_ret_n = gap_ret;
`endif
        case (state)
            IDLE: state_n = WR;
            WR: begin
                if (aw_fire) aw_done_n = 1'b1;
                if (w_fire)  w_done_n  = 1'b1;
                // AW and W may complete in either order or together.
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_n   = WAIT_B;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            WAIT_B: if (i_axi_m_bvalid) begin
                hop = 1'b1;
                tgt = RD;
            end
            RD: if (i_axi_m_arready) state_n = WAIT_R;
            WAIT_R: if (i_axi_m_rvalid) begin
                idx_n = idx + 32'd1;
                if (idx_n == 32'(TRANSACTION_NB)) state_n = DONE;
                else begin
                    hop = 1'b1;
                    tgt = WR;
                end
            end
`ifdef AXI_CPU_MANAGER_RANDOM_GAP_EN
            GAP: begin
                gap_cnt_n = gap_cnt - 3'd1;
                if (gap_cnt == 3'd1) state_n = gap_ret;
            end
`endif
            DONE: state_n = DONE;
            default: state_n = IDLE;
        endcase

        if (hop) begin
`ifdef AXI_CPU_MANAGER_RANDOM_GAP_EN
            lfsr_step = 1'b1;
            if (lfsr_q[2:0] != 3'd0) begin
                state_n   = GAP;
                gap_cnt_n = lfsr_q[2:0];
                gap_ret_n = tgt;
            end else begin
                state_n = tgt;
            end
`else
            state_n = tgt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule
